mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Sequential arbiter sharing the single-ported RAM between the instruction-fetch port and the data port of the datapath/cache interface.
- Registers a grant and drives RAM address, control and store data from the granted requester. Returns load data and per-port wait signals.
- Sits between the datapath_cache_if request side (iREN/dREN/dWEN) and the RAM interface (ramREN/ramWEN/ramstate).

Parameters:
- STARVE_LIMIT, 4, consecutive data grants allowed while a fetch waits (used only with the optional feature)
- ADDR_W, 32, address and data width (word_t)

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  instruction read request
- iaddr  in  32  instruction address
- iwait  out  1  instruction port stalled
- iload  out  32  instruction read data
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data address
- dstore  in  32  data write value
- dwait  out  1  data port stalled
- dload  out  32  data read data
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  ramstate_t: FREE=0, BUSY=1, ACCESS=2, ERROR=3

Behaviour:
- Clock and reset are decided: one clock, CLK; reset nRST is asynchronous and active-low.
- Reset: state=IDLE, starvation counter=0. ramREN, ramWEN, ramaddr and ramstore are 0.
- States: IDLE, IREAD, DREAD, DWRITE. State is registered.
- IDLE sampling priority: dWEN -> DWRITE, else dREN -> DREAD, else iREN -> IREAD, else stay in IDLE.
- Grant latency: a request seen in IDLE is driven on RAM from the next cycle.
- Grant outputs:
  - IREAD: ramREN=1, ramaddr=iaddr.
  - DREAD: ramREN=1, ramaddr=daddr.
  - DWRITE: ramWEN=1, ramaddr=daddr, ramstore=dstore.
  - All other states: RAM strobes 0.
- Completion:
  - In a grant state with ramstate==ACCESS, the granted port's wait is 0 that cycle (combinational).
  - Next state is IDLE, so there is no back-to-back grant without passing through IDLE.
- BUSY/FREE: stay in the grant state with wait=1.
- ERROR: stay in the grant state with wait=1. There is no retry counter; RAM recovery is the RAM's concern.
- Abort: if the granted request drops before ACCESS, go to IDLE next cycle and deassert the strobes in that cycle.
- Wait outputs:
  - iwait = iREN and not (state==IREAD and ramstate==ACCESS).
  - dwait = (dREN or dWEN) and not (state in DREAD/DWRITE and ramstate==ACCESS).
  - Both waits are 0 when the port is idle.
- Load data: iload = ramload and dload = ramload, unconditionally. Data is valid only in the cycle the corresponding wait is 0.
- dREN and dWEN asserted together is a protocol violation; the write wins.
- Asynchronous reset mid-grant: the strobes drop immediately and the in-flight access is lost.

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- With the macro:
  - The counter increments on each completed data access while iREN=1.
  - The counter clears on a completed instruction access, or when iREN=0.
  - When the counter reaches STARVE_LIMIT, IDLE grants iREN ahead of the data port once; that instruction completion clears the counter.
- Without the macro: strict data priority, and no counter exists.

Decomposition:
- cpu_types_pkg: ramstate_t and word_t (existing); add arb_state_t enum {IDLE, IREAD, DREAD, DWRITE}.
- Single module. The starvation counter stays inline; a sub-module is not warranted.

Test Plan:
- Instruction read only: iREN=1, iaddr=0x40. RAM returns ACCESS in the 3rd cycle with ramload=0x8C220004 -> ramREN=1 and ramaddr=0x40 from cycle 2; iwait=0 in the ACCESS cycle; iload=0x8C220004; state IDLE after.
- Contention: iREN=1 and dREN=1 together, daddr=0x100 -> DREAD is granted first and iwait stays 1. After the data ACCESS, state goes to IDLE and then IREAD with ramaddr=iaddr.
- Write: dWEN=1, daddr=0x200, dstore=0xDEADBEEF, ramstate BUSY for 2 cycles then ACCESS -> ramWEN=1, ramstore=0xDEADBEEF throughout; dwait=1 for 3 cycles, then 0.
- Abort: dREN=1 granted, dREN drops at BUSY -> state IDLE next cycle, ramREN=0, dwait=0.
- Reset mid-grant: nRST low asynchronously during DWRITE -> ramWEN=0 immediately, no clock needed; state IDLE.
- Starvation guard (with MEM_ARB_STARVE_GUARD_EN, STARVE_LIMIT=4): iREN held while 5 data reads are requested back-to-back -> the 5th grant is IREAD.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: RAM handshake state, machine word,
// and the arbiter grant state.
package mem_arbiter_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IREAD  = 2'd1,
        DREAD  = 2'd2,
        DWRITE = 2'd3
    } arb_state_t;

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported RAM between the instruction-fetch
// port and the data port. A request seen in IDLE is granted on the next
// cycle; each grant returns to IDLE on completion or abort.
// Optional build macro MEM_ARB_STARVE_GUARD_EN adds a starvation counter
// that lets a waiting fetch overtake the data port after STARVE_LIMIT
// consecutive data completions.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ADDR_W       = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [ADDR_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [ADDR_W-1:0] dstore,
    output logic              dwait,
    output logic [ADDR_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [ADDR_W-1:0] ramstore,
    input  logic [ADDR_W-1:0] ramload,
    input  logic [1:0]        ramstate
);

    if (STARVE_LIMIT < 1) begin : g_limit_check
        $error("mem_arbiter: STARVE_LIMIT must be at least 1");
    end

    arb_state_t state_r;
    arb_state_t state_nxt_s;
    logic       req_held_s;   // granted requester still asserting its request
    logic       ram_done_s;   // RAM reports ACCESS this cycle
    logic       xfer_done_s;  // granted access completes this cycle
    logic       data_grant_s;
    logic       starve_s;     // fetch must overtake the data port

    assign ram_done_s   = (ramstate == 2'(ACCESS));
    assign xfer_done_s  = req_held_s & ram_done_s;
    assign data_grant_s = (state_r == DREAD) | (state_r == DWRITE);

    // Select the request line belonging to the current grant.
    always_comb begin
        req_held_s = 1'b0;
        case (state_r)
            IREAD:   req_held_s = iREN;
            DREAD:   req_held_s = dREN;
            DWRITE:  req_held_s = dWEN;
            IDLE:    req_held_s = 1'b0;
            default: req_held_s = 1'b0;
        endcase
    end

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt_r;

    assign starve_s = iREN & (starve_cnt_r >= CNT_W'(STARVE_LIMIT));

    // Count data completions that happen while a fetch is left waiting.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (!iREN) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == IREAD) && xfer_done_s) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (data_grant_s && xfer_done_s &&
                     (starve_cnt_r < CNT_W'(STARVE_LIMIT))) begin
            starve_cnt_r <= starve_cnt_r + CNT_W'(1);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end
`else
    assign starve_s = 1'b0;
`endif

    // Grant state register; asynchronous reset drops any in-flight access.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next grant: write > read > fetch in IDLE, unless the fetch is starved;
    // a grant ends on completion or when its request is withdrawn.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (starve_s) begin
                    state_nxt_s = IREAD;
                end else if (dWEN) begin
                    state_nxt_s = DWRITE;
                end else if (dREN) begin
                    state_nxt_s = DREAD;
                end else if (iREN) begin
                    state_nxt_s = IREAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            IREAD, DREAD, DWRITE: begin
                if (!req_held_s || ram_done_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Steer the granted requester onto the RAM; strobes follow the live
    // request so an abort releases the RAM in the same cycle.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = {ADDR_W{1'b0}};
        ramstore = {ADDR_W{1'b0}};
        case (state_r)
            IREAD: begin
                ramREN  = iREN;
                ramaddr = iaddr;
            end
            DREAD: begin
                ramREN  = dREN;
                ramaddr = daddr;
            end
            DWRITE: begin
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
            end
            IDLE: begin
                ramREN = 1'b0;
            end
            default: begin
                ramREN = 1'b0;
            end
        endcase
    end

    // A port stalls while it requests and its grant has not reached ACCESS.
    always_comb begin
        iwait = iREN & ~((state_r == IREAD) & ram_done_s);
        dwait = (dREN | dWEN) & ~(data_grant_s & ram_done_s);
    end

    assign iload = ramload;
    assign dload = ramload;

endmodule : mem_arbiter
